// File: rtl/mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide unit: width, funct3 encodings
// and FSM states.
package mdu_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation: magnitude extraction on the way in,
// sign restoration on the way out.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  always_comb begin
    res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit with start/busy/done handshake; one
// shift-add or restoring-divide step per cycle over a shared 128-bit accumulator.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  output logic            busy,
  output logic            done,
  output logic            wen,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [5:0]        cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic [XLEN-1:0]   mcand_q, result_q;
  logic              neg_res_q, neg_rem_q;

  logic              accept, special, a_signed, b_signed;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;

  always_comb begin
    a_signed = (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
               (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
    b_signed = (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
    special     = 1'b0;
    special_res = '0;
    if (funct3[2]) begin
      if (rs2_data == '0) begin
        special     = 1'b1;
        special_res = funct3[1] ? rs1_data : '1;
      end else if (b_signed && rs1_data == INT_MIN && rs2_data == '1) begin
        special     = 1'b1;
        special_res = funct3[1] ? '0 : rs1_data;
      end
    end
  end

  mdu_sign_fix #(.W(XLEN)) u_mag_a (
    .val (rs1_data),
    .neg (a_signed && rs1_data[XLEN-1]),
    .res (a_mag)
  );

  mdu_sign_fix #(.W(XLEN)) u_mag_b (
    .val (rs2_data),
    .neg (b_signed && rs2_data[XLEN-1]),
    .res (b_mag)
  );

  // Multiply: {hi, multiplier} shifts right. Divide: {remainder, quotient} shifts left.
  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = div_shift >= {1'b0, mcand_q};
    div_diff  = div_shift[XLEN-1:0] - mcand_q;
    if (op_q[2]) begin
      acc_nxt = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    fix_in = acc_nxt;
    if (op_q[2]) begin
      fix_in = {{XLEN{1'b0}}, op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0]};
    end
    fix_neg = (op_q[2] && op_q[1]) ? neg_rem_q : neg_res_q;
  end

  mdu_sign_fix #(.W(2*XLEN)) u_fix_res (
    .val (fix_in),
    .neg (fix_neg),
    .res (fix_out)
  );

  always_comb begin
    final_res = (op_q[2] || op_q == MDU_MUL) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
  end

  assign accept = start && (state_q != CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == 6'd63) state_d = DONE;
      DONE:    state_d = start ? (special ? DONE : CALC) : IDLE;
      default: state_d = IDLE;
    endcase
    busy = (state_q == CALC);
    done = (state_q == DONE);
    wen  = done && (rd_q != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      result_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      op_q      <= funct3;
      rd_q      <= rd_addr_in;
      cnt_q     <= '0;
      acc_q     <= {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
      mcand_q   <= funct3[2] ? b_mag : a_mag;
      neg_res_q <= (a_signed && rs1_data[XLEN-1]) ^ (b_signed && rs2_data[XLEN-1]);
      neg_rem_q <= a_signed && rs1_data[XLEN-1];
      if (special) result_q <= special_res;
    end else if (state_q == CALC) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q == 6'd63) result_q <= final_res;
    end
  end

  assign rd_addr_out = rd_q;
  assign result      = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver queues reference results, monitor
// pops and compares on every done cycle, including latency and write enable.
module tb_mul_div_unit;

  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] rs1_data = '0;
  logic [63:0] rs2_data = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        busy, done, wen;
  logic [4:0]  rd_addr_out;
  logic [63:0] result;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .funct3      (funct3),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rd_addr_in  (rd_addr_in),
    .busy        (busy),
    .done        (done),
    .wen         (wen),
    .rd_addr_out (rd_addr_out),
    .result      (result)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    bit          special;
    int          acc_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   dones_seen = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    return f[2] && ((b == 64'd0) || (!f[0] && a == INT_MIN && b == {64{1'b1}}));
  endfunction

  function automatic logic [63:0] ref_model(input logic [2:0] f, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'b000: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
      3'b001: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return p[127:64]; end
      3'b010: begin p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); return p[127:64]; end
      3'b011: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'b100: begin
        if (b == 64'd0) return {64{1'b1}};
        if (a == INT_MIN && b == {64{1'b1}}) return a;
        return sa / sb;
      end
      3'b101: return (b == 64'd0) ? {64{1'b1}} : a / b;
      3'b110: begin
        if (b == 64'd0) return a;
        if (a == INT_MIN && b == {64{1'b1}}) return 64'd0;
        return sa % sb;
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 100));
      2: return 64'd0;
      3: return {64{1'b1}};
      4: return INT_MIN;
      default: return -64'($urandom_range(1, 100));
    endcase
  endfunction

  // Monitor: every cycle with done high is one completion.
  exp_t m;
  always @(negedge clk) begin
    if (rst_n && done) begin
      dones_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=%0d with no operation pending (t=%0t)", done, $time);
      end else begin
        m = exp_q.pop_front();
        chk("result", result, m.res);
        chk("rd_addr_out", 64'(rd_addr_out), 64'(m.rd));
        chk("wen", 64'(wen), 64'(m.rd != 5'd0));
        chk("latency", 64'(edge_cnt - m.acc_edge), m.special ? 64'd0 : 64'd64);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: busy=%0d after %0d cycles, required 0", busy, n);
      return;
    end
    start      = 1'b1;
    funct3     = f;
    rs1_data   = a;
    rs2_data   = b;
    rd_addr_in = rd;
    e.res      = ref_model(f, a, b);
    e.rd       = rd;
    e.special  = is_special(f, a, b);
    e.acc_edge = edge_cnt + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start      = 1'b0;
    rs1_data   = {$urandom, $urandom};
    rs2_data   = {$urandom, $urandom};
    funct3     = 3'($urandom);
    rd_addr_in = 5'($urandom);
    chk("busy_after_accept", 64'(busy), 64'(!e.special));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_wen", 64'(wen), 64'd0);
    chk("reset_rd", 64'(rd_addr_out), 64'd0);
    chk("reset_result", result, 64'd0);
    rst_n = 1'b1;

    issue(3'b000, 64'd7, 64'd9, 5'd3);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("result_held", result, 64'd63);

    issue(3'b011, {64{1'b1}}, {64{1'b1}}, 5'd4);
    issue(3'b001, {64{1'b1}}, {64{1'b1}}, 5'd5);
    issue(3'b010, {64{1'b1}}, 64'd2, 5'd6);
    issue(3'b100, -64'sd7, 64'd2, 5'd7);
    issue(3'b110, -64'sd7, 64'd2, 5'd8);
    issue(3'b101, 64'd100, 64'd7, 5'd9);
    issue(3'b111, 64'd100, 64'd7, 5'd10);
    issue(3'b101, 64'd5, 64'd0, 5'd11);
    issue(3'b110, 64'd5, 64'd0, 5'd12);
    issue(3'b100, INT_MIN, {64{1'b1}}, 5'd13);
    issue(3'b110, INT_MIN, {64{1'b1}}, 5'd14);
    wait_idle();

    // Start while busy must be ignored
    issue(3'b000, 64'd12345, 64'd1000, 5'd15);
    repeat (9) @(negedge clk);
    chk("busy_mid_calc", 64'(busy), 64'd1);
    start = 1'b1; funct3 = 3'b101; rs1_data = 64'd77; rs2_data = 64'd0; rd_addr_in = 5'd16;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of a divide
    issue(3'b100, -64'sd7000, 64'd3, 5'd17);
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_wen", 64'(wen), 64'd0);
    chk("abort_rd", 64'(rd_addr_out), 64'd0);
    chk("abort_result", result, 64'd0);
    exp_q.delete();
    d0 = dones_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    chk("no_done_after_abort", 64'(dones_seen), 64'(d0));

    issue(3'b101, 64'd1000, 64'd10, 5'd18);
    issue(3'b000, 64'd3, 64'd4, 5'd0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
